// File: rtl/lvds_rx_init_seq_mc_if.sv
// Control/status bundle between the LVDS receiver bring-up sequencer and its environment.
// Ports: slave = sequencer side (lock/mode inputs in, reset/ready outputs out);
//        master = environment side (drives lock/mode inputs, observes resets and status).
interface lvds_rx_init_seq_mc_if #(
  parameter int N_CH = 4
);
  logic            user_mode;
  logic            rx_locked;
  logic [N_CH-1:0] rx_dpa_locked;
  logic            restart;
  logic            pll_areset;
  logic [N_CH-1:0] rx_reset;
  logic [N_CH-1:0] rx_fifo_reset;
  logic [N_CH-1:0] rx_cda_reset;
  logic [N_CH-1:0] ch_ready;
  logic            init_done;
  logic            fail;
  logic [2:0]      monitor;

  modport slave (
    input  user_mode, rx_locked, rx_dpa_locked, restart,
    output pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset, ch_ready, init_done, fail, monitor
  );

  modport master (
    output user_mode, rx_locked, rx_dpa_locked, restart,
    input  pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset, ch_ready, init_done, fail, monitor
  );
endinterface

// File: rtl/lvds_rx_init_seq_mc.sv
// Multi-channel LVDS receiver bring-up sequencer: PLL reset, per-channel rx/FIFO/CDA resets, lock tracking.
// Latency: async inputs see 2-cycle synchronisers; all outputs registered, updated with the state register.
// No backpressure: free-running control FSM; restart is a single-cycle clk-synchronous request.
// Ports: clk, rst (sync, active-high); bus (slave modport): user_mode, rx_locked, rx_dpa_locked, restart in;
//        pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset, ch_ready, init_done, fail, monitor out.
// Optional feature: define LVDS_INIT_TIMEOUT_EN for DPA-lock timeout with bounded retries and a FAIL state.
module lvds_rx_init_seq_mc #(
  parameter int N_CH         = 4,
  parameter int PLL_RST_CYC  = 16,
  parameter int SETTLE_CYC   = 8,
  parameter int FIFO_RST_CYC = 4,
  parameter int CDA_RST_CYC  = 4,
  parameter int DPA_TIMEOUT  = 1024,
  parameter int MAX_RETRY    = 3
) (
  input logic                  clk,
  input logic                  rst,
  lvds_rx_init_seq_mc_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT_UM   = 3'd0,
    S_PLL_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_DPA_WAIT  = 3'd3,
    S_FIFO_RST  = 3'd4,
    S_CDA_RST   = 3'd5,
    S_DONE      = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  // One shared counter sized for the longest interval it ever has to time.
  localparam int MAX_AB  = (PLL_RST_CYC > SETTLE_CYC) ? PLL_RST_CYC : SETTLE_CYC;
  localparam int MAX_CD  = (FIFO_RST_CYC > CDA_RST_CYC) ? FIFO_RST_CYC : CDA_RST_CYC;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
`ifdef LVDS_INIT_TIMEOUT_EN
  localparam int CNT_MAX = (MAX_ABCD > DPA_TIMEOUT) ? MAX_ABCD : DPA_TIMEOUT;
`else
  localparam int CNT_MAX = MAX_ABCD;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_TOP     = CW'(CNT_MAX);
  localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] FIFO_LAST   = CW'(FIFO_RST_CYC - 1);
  localparam logic [CW-1:0] CDA_LAST    = CW'(CDA_RST_CYC - 1);

  // Two-flop synchronisers for the asynchronous inputs.
  logic            um_meta, um_s;
  logic            lk_meta, lk_s;
  logic [N_CH-1:0] dpa_meta, dpa_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      um_meta  <= 1'b0;
      um_s     <= 1'b0;
      lk_meta  <= 1'b0;
      lk_s     <= 1'b0;
      dpa_meta <= '0;
      dpa_s    <= '0;
    end else begin
      um_meta  <= bus.user_mode;
      um_s     <= um_meta;
      lk_meta  <= bus.rx_locked;
      lk_s     <= lk_meta;
      dpa_meta <= bus.rx_dpa_locked;
      dpa_s    <= dpa_meta;
    end
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            enter;        // a transition is taken this cycle (self re-entry included)
  logic [CW-1:0]   cnt_inc;

  logic            pll_r, pll_nxt;
  logic [N_CH-1:0] rxr_r, rxr_nxt;
  logic [N_CH-1:0] fifo_r, fifo_nxt;
  logic [N_CH-1:0] cda_r, cda_nxt;
  logic [N_CH-1:0] rdy_r, rdy_nxt;
  logic            done_r, done_nxt;

`ifdef LVDS_INIT_TIMEOUT_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] DPA_LAST  = CW'(DPA_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_TOP = RW'(MAX_RETRY);
  logic [RW-1:0] retry_cnt, retry_nxt;
  logic          fail_r;
`else
  // Timeout parameters only matter when the timeout feature is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{DPA_TIMEOUT, MAX_RETRY};
`endif

  // Saturating increment; no interval ever needs to wrap.
  assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;

  // Next-state logic, in priority order: user_mode drop, restart, lock loss, timeout, progression.
  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
`ifdef LVDS_INIT_TIMEOUT_EN
    retry_nxt = retry_cnt;
`endif
    if (!um_s) begin
      state_nxt = S_WAIT_UM;
      enter     = (state != S_WAIT_UM);
`ifdef LVDS_INIT_TIMEOUT_EN
      retry_nxt = '0;
`endif
    end else if (bus.restart && (state != S_WAIT_UM)) begin
      state_nxt = S_PLL_RST;
      enter     = 1'b1;
`ifdef LVDS_INIT_TIMEOUT_EN
      retry_nxt = '0;
`endif
    end else if (!lk_s && (state inside {S_DPA_WAIT, S_FIFO_RST, S_CDA_RST, S_DONE})) begin
      state_nxt = S_PLL_RST;
      enter     = 1'b1;
    end else begin
      case (state)
        S_WAIT_UM: begin
          state_nxt = S_PLL_RST;
          enter     = 1'b1;
        end
        S_PLL_RST: begin
          if (cnt == PLL_LAST) begin
            state_nxt = S_WAIT_LOCK;
            enter     = 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          // Needs SETTLE_CYC consecutive locked samples; the count restarts on any low.
          if (lk_s && (cnt == SETTLE_LAST)) begin
            state_nxt = S_DPA_WAIT;
            enter     = 1'b1;
          end
        end
        S_DPA_WAIT: begin
          if (&dpa_s) begin
            state_nxt = S_FIFO_RST;
            enter     = 1'b1;
          end
`ifdef LVDS_INIT_TIMEOUT_EN
          else if (cnt == DPA_LAST) begin
            enter = 1'b1;
            if (retry_cnt == RETRY_TOP) begin
              state_nxt = S_FAIL;
            end else begin
              state_nxt = S_PLL_RST;
              retry_nxt = retry_cnt + 1'b1;
            end
          end
`endif
        end
        S_FIFO_RST: begin
          if (cnt == FIFO_LAST) begin
            state_nxt = S_CDA_RST;
            enter     = 1'b1;
          end
        end
        S_CDA_RST: begin
          if (cnt == CDA_LAST) begin
            state_nxt = S_DONE;
            enter     = 1'b1;
          end
        end
        S_DONE: begin
`ifdef LVDS_INIT_TIMEOUT_EN
          retry_nxt = '0;
`endif
        end
        S_FAIL: begin
          // Sticky until rst, restart or a user_mode drop (all handled above).
        end
        default: begin
          state_nxt = S_WAIT_UM;
          enter     = 1'b1;
        end
      endcase
    end
  end

  // Interval counter: cleared on every state entry, counts only in timed states.
  always_comb begin
    cnt_nxt = '0;
    if (!enter) begin
      case (state)
        S_PLL_RST:   cnt_nxt = cnt_inc;
        S_WAIT_LOCK: cnt_nxt = lk_s ? cnt_inc : '0;
        S_FIFO_RST:  cnt_nxt = cnt_inc;
        S_CDA_RST:   cnt_nxt = cnt_inc;
`ifdef LVDS_INIT_TIMEOUT_EN
        S_DPA_WAIT:  cnt_nxt = cnt_inc;
`endif
        default:     cnt_nxt = '0;
      endcase
    end
  end

  // Output decode from the next state so outputs change on the same edge as the state.
  always_comb begin
    pll_nxt  = 1'b0;
    rxr_nxt  = '0;
    fifo_nxt = '0;
    cda_nxt  = '0;
    rdy_nxt  = '0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_WAIT_UM, S_PLL_RST, S_FAIL: begin
        pll_nxt = 1'b1;
        rxr_nxt = '1;
      end
      S_WAIT_LOCK: rxr_nxt  = '1;
      S_FIFO_RST:  fifo_nxt = '1;
      S_CDA_RST:   cda_nxt  = '1;
      S_DONE: begin
        done_nxt = 1'b1;
        rdy_nxt  = dpa_s;   // per-channel: DPA loss clears only that channel's bit
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_WAIT_UM;
      cnt    <= '0;
      pll_r  <= 1'b1;
      rxr_r  <= '1;
      fifo_r <= '0;
      cda_r  <= '0;
      rdy_r  <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pll_r  <= pll_nxt;
      rxr_r  <= rxr_nxt;
      fifo_r <= fifo_nxt;
      cda_r  <= cda_nxt;
      rdy_r  <= rdy_nxt;
      done_r <= done_nxt;
    end
  end

`ifdef LVDS_INIT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
      fail_r    <= 1'b0;
    end else begin
      retry_cnt <= retry_nxt;
      fail_r    <= (state_nxt == S_FAIL);
    end
  end
  assign bus.fail = fail_r;
`else
  assign bus.fail = 1'b0;
`endif

  assign bus.pll_areset    = pll_r;
  assign bus.rx_reset      = rxr_r;
  assign bus.rx_fifo_reset = fifo_r;
  assign bus.rx_cda_reset  = cda_r;
  assign bus.ch_ready      = rdy_r;
  assign bus.init_done     = done_r;
  assign bus.monitor       = state;

endmodule

// File: tb/tb_lvds_rx_init_seq_mc.sv
// Directed vector bench for the LVDS receiver bring-up sequencer (N_CH=4, DPA_TIMEOUT=64, MAX_RETRY=2).
// Each vector sets inputs, advances a number of clock edges, then compares all outputs 1 time unit after the edge.
// Hand-written tail sequence measures pll_areset, fifo and cda pulse widths after a fresh reset.
module tb_lvds_rx_init_seq_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lvds_rx_init_seq_mc_if #(.N_CH(4)) ifc ();

  lvds_rx_init_seq_mc #(
    .N_CH        (4),
    .PLL_RST_CYC (16),
    .SETTLE_CYC  (8),
    .FIFO_RST_CYC(4),
    .CDA_RST_CYC (4),
    .DPA_TIMEOUT (64),
    .MAX_RETRY   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  // Packed output view: {monitor, pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset, ch_ready, init_done, fail}
  typedef struct {
    logic        rst;
    logic        um;
    logic        lk;
    logic [3:0]  dpa;
    logic        rs;
    int          n;
    logic [21:0] exp;
  } vec_t;

  vec_t vec_q[$];

  // Expected outputs for each state, straight from the state/output table.
  function automatic logic [21:0] ex(input logic [2:0] s, input logic [3:0] rdy);
    logic [21:0] v;
    case (s)
      3'd0:    v = {3'd0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      3'd1:    v = {3'd1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      3'd2:    v = {3'd2, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      3'd3:    v = {3'd3, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      3'd4:    v = {3'd4, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0};
      3'd5:    v = {3'd5, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0};
      3'd6:    v = {3'd6, 1'b0, 4'h0, 4'h0, 4'h0, rdy,  1'b1, 1'b0};
      default: v = {3'd7, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    endcase
    return v;
  endfunction

  function automatic void add(input logic r, input logic um, input logic lk, input logic [3:0] dpa,
                              input logic rs, input int n, input logic [21:0] e);
    vec_t v;
    v.rst = r; v.um = um; v.lk = lk; v.dpa = dpa; v.rs = rs; v.n = n; v.exp = e;
    vec_q.push_back(v);
  endfunction

  function automatic logic [21:0] act();
    return {ifc.monitor, ifc.pll_areset, ifc.rx_reset, ifc.rx_fifo_reset, ifc.rx_cda_reset,
            ifc.ch_ready, ifc.init_done, ifc.fail};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  initial begin
    int k;
    int width;

    // Nominal bring-up from reset.
    add(1, 1, 1, 4'hF, 0, 2,  ex(0, 4'h0));
    add(0, 1, 1, 4'hF, 0, 2,  ex(0, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(1, 4'h0));
    add(0, 1, 1, 4'hF, 0, 15, ex(1, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(2, 4'h0));
    add(0, 1, 1, 4'hF, 0, 7,  ex(2, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(3, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(4, 4'h0));
    add(0, 1, 1, 4'hF, 0, 3,  ex(4, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(5, 4'h0));
    add(0, 1, 1, 4'hF, 0, 3,  ex(5, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(6, 4'hF));
    // Single-channel DPA loss in DONE.
    add(0, 1, 1, 4'hB, 0, 2,  ex(6, 4'hF));
    add(0, 1, 1, 4'hB, 0, 1,  ex(6, 4'hB));
    add(0, 1, 1, 4'hF, 0, 3,  ex(6, 4'hF));
    // PLL lock loss in DONE, then relock and full re-sequence.
    add(0, 1, 0, 4'hF, 0, 2,  ex(6, 4'hF));
    add(0, 1, 0, 4'hF, 0, 1,  ex(1, 4'h0));
    add(0, 1, 1, 4'hF, 0, 15, ex(1, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(2, 4'h0));
    add(0, 1, 1, 4'hF, 0, 17, ex(6, 4'hF));
    // rst while in DONE.
    add(1, 1, 1, 4'hF, 0, 1,  ex(0, 4'h0));
    add(0, 1, 1, 4'hF, 0, 2,  ex(0, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(1, 4'h0));
    // Lock glitch after 5 settle cycles restarts the settle count.
    add(0, 1, 0, 4'hF, 0, 15, ex(1, 4'h0));
    add(0, 1, 0, 4'hF, 0, 1,  ex(2, 4'h0));
    add(0, 1, 1, 4'hF, 0, 5,  ex(2, 4'h0));
    add(0, 1, 0, 4'hF, 0, 1,  ex(2, 4'h0));
    add(0, 1, 1, 4'hF, 0, 4,  ex(2, 4'h0));
    add(0, 1, 1, 4'hF, 0, 5,  ex(2, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(3, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(4, 4'h0));
    add(0, 1, 1, 4'hF, 0, 4,  ex(5, 4'h0));
    // user_mode drop truncates the CDA pulse.
    add(0, 0, 1, 4'hF, 0, 2,  ex(5, 4'h0));
    add(0, 0, 1, 4'hF, 0, 1,  ex(0, 4'h0));
    // Channel 3 never DPA-locks.
    add(0, 1, 1, 4'h7, 0, 3,  ex(1, 4'h0));
    add(0, 1, 1, 4'h7, 0, 16, ex(2, 4'h0));
    add(0, 1, 1, 4'h7, 0, 8,  ex(3, 4'h0));
`ifdef LVDS_INIT_TIMEOUT_EN
    add(0, 1, 1, 4'h7, 0, 63, ex(3, 4'h0));
    add(0, 1, 1, 4'h7, 0, 1,  ex(1, 4'h0));
    add(0, 1, 1, 4'h7, 0, 24, ex(3, 4'h0));
    add(0, 1, 1, 4'h7, 0, 63, ex(3, 4'h0));
    add(0, 1, 1, 4'h7, 0, 1,  ex(1, 4'h0));
    add(0, 1, 1, 4'h7, 0, 24, ex(3, 4'h0));
    add(0, 1, 1, 4'h7, 0, 63, ex(3, 4'h0));
    add(0, 1, 1, 4'h7, 0, 1,  ex(7, 4'h0));
    add(0, 1, 1, 4'h7, 0, 10, ex(7, 4'h0));
    add(0, 1, 1, 4'h7, 1, 1,  ex(1, 4'h0));
    add(0, 1, 1, 4'hF, 0, 32, ex(5, 4'h0));
    add(0, 1, 1, 4'hF, 0, 1,  ex(6, 4'hF));
`else
    add(0, 1, 1, 4'h7, 0, 200, ex(3, 4'h0));
    add(0, 1, 1, 4'hF, 0, 3,  ex(4, 4'h0));
    // restart mid-pulse truncates the FIFO reset.
    add(0, 1, 1, 4'hF, 1, 1,  ex(1, 4'h0));
    add(0, 1, 1, 4'hF, 0, 16, ex(2, 4'h0));
`endif

    for (int i = 0; i < vec_q.size(); i++) begin
      rst               = vec_q[i].rst;
      ifc.user_mode     = vec_q[i].um;
      ifc.rx_locked     = vec_q[i].lk;
      ifc.rx_dpa_locked = vec_q[i].dpa;
      ifc.restart       = vec_q[i].rs;
      repeat (vec_q[i].n) @(posedge clk);
      #1;
      checks++;
      if (act() !== vec_q[i].exp) begin
        failures++;
        $display("FAIL vec%0d: outputs got %h expected %h", i, act(), vec_q[i].exp);
      end
    end

    // Pulse-width measurement after a fresh reset.
    rst = 1'b1; ifc.user_mode = 1'b1; ifc.rx_locked = 1'b1; ifc.rx_dpa_locked = 4'hF; ifc.restart = 1'b0;
    step();
    rst = 1'b0;
    k = 0;
    while (ifc.monitor != 3'd1 && k < 10) begin step(); k++; end
    chk("enter_pll_rst", int'(ifc.monitor), 1);
    width = 0;
    while (ifc.pll_areset && width < 40) begin step(); width++; end
    chk("pll_areset_width", width, 16);
    k = 0;
    while (ifc.rx_fifo_reset != 4'hF && k < 100) begin step(); k++; end
    chk("fifo_seen", int'(ifc.rx_fifo_reset), 15);
    width = 0;
    while (ifc.rx_fifo_reset == 4'hF && width < 40) begin step(); width++; end
    chk("fifo_width", width, 4);
    width = 0;
    while (ifc.rx_cda_reset == 4'hF && width < 40) begin step(); width++; end
    chk("cda_width", width, 4);
    chk("done_state", int'(ifc.monitor), 6);
    chk("done_flag", int'(ifc.init_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
